mtt_tlb: RTL and testbench

- Small fully-associative cache of MTT walk results; sits directly upstream of the MTT page-table walker.
- Accepts physical-address access checks from the core/LSU.
- A hit answers in one cycle from cached per-page permissions.
- A miss launches one walk on the walker's control port, installs the result, then answers.

---
 rtl/mtt_tlb.sv | 193 +++++++++++++++++++
 tb/tb_mtt_tlb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtt_tlb.sv
// Fully-associative cache of MTT walk results in front of the page-table walker.
// Optional hit/miss counters are enabled with `define MTT_TLB_PERF_CNT_EN.
module mtt_tlb #(
  parameter int ADDR_LEN    = 56,
  parameter int NUM_ENTRIES = 4,
  parameter int PAGE_SHIFT  = 12
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_LEN-1:0] req_paddr_i,
  input  logic [2:0]          req_access_i,
  output logic                resp_valid_o,
  output logic                resp_allow_o,
  output logic                resp_fault_o,
`ifdef MTT_TLB_PERF_CNT_EN
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
`endif
  output logic                ptw_enable_o,
  output logic                ptw_addr_valid_o,
  output logic [ADDR_LEN-1:0] ptw_paddr_o,
  input  logic                ptw_busy_i,
  input  logic                ptw_valid_i,
  input  logic                ptw_fault_i,
  input  logic [2:0]          ptw_perm_i
);

  localparam int TAG_W = ADDR_LEN - PAGE_SHIFT;
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PTW_REQ,
    ST_PTW_WAIT,
    ST_RESP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag  [NUM_ENTRIES];
  logic [2:0]             r_perm [NUM_ENTRIES];
  logic [IDX_W-1:0]       r_ptr;

  logic [ADDR_LEN-1:0]    r_paddr;
  logic [2:0]             r_access;
  logic                   r_allow;
  logic                   r_fault;
  logic                   r_drop;

  logic [TAG_W-1:0]       w_req_tag;
  logic [NUM_ENTRIES-1:0] w_hit_vec;
  logic [2:0]             w_hit_perm;
  logic                   w_hit;
  logic                   w_free_found;
  logic [IDX_W-1:0]       w_free_idx;
  logic [IDX_W-1:0]       w_victim;
  logic                   w_accept;
  logic                   w_walk_busy;
  logic                   w_walk_ok;
  logic                   w_walk_fault;
  logic                   w_install;

  assign w_req_tag = req_paddr_i[ADDR_LEN-1:PAGE_SHIFT];

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_perm = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_req_tag)) begin
        w_hit_vec[i] = 1'b1;
        w_hit_perm   = w_hit_perm | r_perm[i];
      end
    end
  end

  // A request arriving with a flush must not be served from entries being cleared.
  assign w_hit = (|w_hit_vec) && !flush_i;

  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_free_found = ~&r_valid;
  assign w_victim     = w_free_found ? w_free_idx : r_ptr;

  assign w_accept     = req_valid_i && (r_state == ST_IDLE);
  assign w_walk_busy  = (r_state == ST_PTW_REQ) || (r_state == ST_PTW_WAIT);
  assign w_walk_fault = (r_state == ST_PTW_WAIT) && ptw_fault_i;
  assign w_walk_ok    = (r_state == ST_PTW_WAIT) && ptw_valid_i && !ptw_fault_i;
  assign w_install    = w_walk_ok && !r_drop && !flush_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (req_valid_i) w_state_nxt = w_hit ? ST_RESP : ST_PTW_REQ;
      ST_PTW_REQ:  if (ptw_busy_i) w_state_nxt = ST_PTW_WAIT;
      ST_PTW_WAIT: if (ptw_valid_i || ptw_fault_i) w_state_nxt = ST_RESP;
      ST_RESP:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_paddr  <= '0;
      r_access <= '0;
      r_allow  <= 1'b0;
      r_fault  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_paddr  <= req_paddr_i;
        r_access <= req_access_i;
        r_allow  <= |(req_access_i & w_hit_perm);
        r_fault  <= 1'b0;
        r_drop   <= 1'b0;
      end else begin
        if (w_walk_busy && flush_i) r_drop <= 1'b1;
        if (w_walk_fault) begin
          r_allow <= 1'b0;
          r_fault <= 1'b1;
        end else if (w_walk_ok) begin
          r_allow <= |(r_access & ptw_perm_i);
          r_fault <= 1'b0;
        end
      end
    end
  end

  // The pointer only moves when a full cache has to evict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else begin
      if (flush_i)        r_valid           <= '0;
      else if (w_install) r_valid[w_victim] <= 1'b1;
      if (w_install && !w_free_found) r_ptr <= r_ptr + 1'b1;
    end
  end

  // NOTE: tag and permission storage has no reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk_i) begin
    if (w_install) begin
      r_tag[w_victim]  <= r_paddr[ADDR_LEN-1:PAGE_SHIFT];
      r_perm[w_victim] <= ptw_perm_i;
    end
  end

`ifdef MTT_TLB_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF))    r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!w_hit && (r_miss_cnt != 32'hFFFF_FFFF))  r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

  assign req_ready_o      = (r_state == ST_IDLE);
  assign resp_valid_o     = (r_state == ST_RESP);
  assign resp_allow_o     = (r_state == ST_RESP) && r_allow;
  assign resp_fault_o     = (r_state == ST_RESP) && r_fault;
  assign ptw_enable_o     = w_walk_busy;
  assign ptw_addr_valid_o = (r_state == ST_PTW_REQ);
  assign ptw_paddr_o      = r_paddr;

  a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(w_hit_vec));

endmodule

// File: tb/tb_mtt_tlb.sv
// Scoreboard bench for mtt_tlb: expected responses are queued when a request is
// driven and compared by a monitor when resp_valid_o pulses.
module tb_mtt_tlb;

  localparam int AL = 56;
  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [AL-1:0] req_paddr;
  logic [2:0]    req_access;
  logic          resp_valid;
  logic          resp_allow;
  logic          resp_fault;
  logic          ptw_enable;
  logic          ptw_addr_valid;
  logic [AL-1:0] ptw_paddr;
  logic          ptw_busy;
  logic          ptw_valid;
  logic          ptw_fault;
  logic [2:0]    ptw_perm;
`ifdef MTT_TLB_PERF_CNT_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  typedef struct packed {
    logic allow;
    logic fault;
  } resp_t;

  resp_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  mtt_tlb #(.ADDR_LEN(AL), .NUM_ENTRIES(4), .PAGE_SHIFT(12)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_paddr_i      (req_paddr),
    .req_access_i     (req_access),
    .resp_valid_o     (resp_valid),
    .resp_allow_o     (resp_allow),
    .resp_fault_o     (resp_fault),
`ifdef MTT_TLB_PERF_CNT_EN
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt),
`endif
    .ptw_enable_o     (ptw_enable),
    .ptw_addr_valid_o (ptw_addr_valid),
    .ptw_paddr_o      (ptw_paddr),
    .ptw_busy_i       (ptw_busy),
    .ptw_valid_i      (ptw_valid),
    .ptw_fault_i      (ptw_fault),
    .ptw_perm_i       (ptw_perm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid=1 allow=%0b fault=%0b, required no response",
                 resp_allow, resp_fault);
      end else begin
        e = exp_q.pop_front();
        if ({resp_allow, resp_fault} !== e) begin
          miscompares++;
          $display("FAIL resp_data: got allow=%0b fault=%0b, required allow=%0b fault=%0b",
                   resp_allow, resp_fault, e.allow, e.fault);
        end
      end
    end
  end

  task automatic run_req(input string name, input logic [AL-1:0] addr, input logic [2:0] acc,
                         input logic exp_hit, input logic exp_allow, input logic exp_fault,
                         input logic walk_fault, input logic [2:0] perm,
                         input logic flush_acc, input logic flush_wait);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: got %0b, required 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_paddr  = addr;
    req_access = acc;
    flush      = flush_acc;
    exp_q.push_back({exp_allow, exp_fault});
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    vectors++;
    if (ptw_enable !== !exp_hit) begin
      miscompares++;
      $display("FAIL %s_ptw_enable: got %0b, required %0b", name, ptw_enable, !exp_hit);
    end
    if (exp_hit) begin
      vectors++;
      if (resp_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_hit_latency: got resp_valid=%0b, required 1", name, resp_valid);
      end
    end else begin
      vectors++;
      if (ptw_addr_valid !== 1'b1 || ptw_paddr !== addr) begin
        miscompares++;
        $display("FAIL %s_ptw_req: got addr_valid=%0b paddr=%0h, required 1 %0h",
                 name, ptw_addr_valid, ptw_paddr, addr);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (ptw_addr_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_ptw_hold: got addr_valid=%0b, required 1", name, ptw_addr_valid);
      end
      ptw_busy = 1'b1;
      @(negedge clk);
      vectors++;
      if (ptw_enable !== 1'b1 || ptw_addr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_ptw_wait: got enable=%0b addr_valid=%0b, required 1 0",
                 name, ptw_enable, ptw_addr_valid);
      end
      if (flush_wait) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      ptw_valid = !walk_fault;
      ptw_fault = walk_fault;
      ptw_perm  = perm;
      @(negedge clk);
      ptw_valid = 1'b0;
      ptw_fault = 1'b0;
      ptw_busy  = 1'b0;
      vectors++;
      if (resp_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_miss_latency: got resp_valid=%0b, required 1", name, resp_valid);
      end
    end
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending responses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_allow !== 1'b0 || resp_fault !== 1'b0 ||
        ptw_enable !== 1'b0 || ptw_addr_valid !== 1'b0 || ptw_paddr !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ready=%0b rv=%0b al=%0b fa=%0b en=%0b av=%0b pa=%0h, required 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_allow, resp_fault, ptw_enable, ptw_addr_valid, ptw_paddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    run_req("cold_miss", 56'h1234, ACC_R, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
  endtask

  task automatic test_hit();
    run_req("hit_w", 56'h1FF0, ACC_W, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_req("hit_r", 56'h1FF0, ACC_R, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_walk_fault();
    run_req("fault",        56'h5000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    run_req("fault_repeat", 56'h5000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
  endtask

  task automatic test_replacement();
    run_req("fill_p1",    56'h1000, ACC_R, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_req("fill_p2",    56'h2000, ACC_W, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0);
    run_req("fill_p3",    56'h3000, ACC_X, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    run_req("fill_p4",    56'h4000, ACC_W, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    run_req("evict_p5",   56'h5000, ACC_R, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
    run_req("keep_p2",    56'h2ABC, ACC_R, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_req("zero_acc",   56'h3000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_req("gone_p1",    56'h1000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    run_req("evict_p6",   56'h6000, ACC_R, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    run_req("gone_p2",    56'h2000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    run_req("keep_p5",    56'h5000, ACC_X, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_req("keep_p4",    56'h4000, ACC_R, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_flush_accept();
    run_req("flush_acc",  56'h4000, ACC_R, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0);
    run_req("post_flush", 56'h4000, ACC_R, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_req("flushed_p5", 56'h5000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
  endtask

  task automatic test_flush_walk();
    run_req("flush_walk", 56'h7000, ACC_W, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1);
    run_req("dropped_p7", 56'h7000, ACC_W, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    run_req("flushed_p4", 56'h4000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_walk();
    @(negedge clk);
    req_valid  = 1'b1;
    req_paddr  = 56'h8000;
    req_access = ACC_R;
    @(negedge clk);
    req_valid = 1'b0;
    ptw_busy  = 1'b1;
    @(negedge clk);
    vectors++;
    if (ptw_enable !== 1'b1 || ptw_addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_walk_setup: got enable=%0b addr_valid=%0b, required 1 0", ptw_enable, ptw_addr_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ptw_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got enable=%0b ready=%0b resp_valid=%0b, required 0 1 0",
               ptw_enable, req_ready, resp_valid);
    end
    ptw_busy = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    ptw_valid = 1'b1;
    ptw_perm  = 3'b111;
    @(negedge clk);
    ptw_valid = 1'b0;
    repeat (3) begin
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_stale_walk: got resp_valid=%0b ready=%0b, required 0 1", resp_valid, req_ready);
      end
      @(negedge clk);
    end
    run_req("rst_cleared", 56'h6000, ACC_R, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
  endtask

  initial begin
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_paddr  = '0;
    req_access = '0;
    ptw_busy   = 1'b0;
    ptw_valid  = 1'b0;
    ptw_fault  = 1'b0;
    ptw_perm   = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_walk_fault();
    test_replacement();
    test_flush_accept();
    test_flush_walk();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
